// File: rtl/verify_cmp.sv
// verify_cmp: constant-time block comparator for the FO re-encryption check.
// Reads len word pairs (A at base_a+i, B at base_b+i, A first) from a shared
// memory and reports whether every pair is equal; the final pair's difference
// is filtered through last_mask. Completion time depends only on len and
// RD_LAT, never on the data.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   start             one-cycle request, honoured only in IDLE or DONE
//   len, base_a,
//   base_b, last_mask operands, captured together with start
//   rd_en, rd_addr    memory read request (registered)
//   din               memory read data, valid RD_LAT cycles after the request
//   busy, done        operation in flight / result available (level)
//   verify_true       1 when the blocks match; only meaningful with done
module verify_cmp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [DATA_W-1:0] last_mask,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              verify_true
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ALL_ZERO = {DATA_W{1'b0}};
    // Tag stages that still have to reach the output stage.
    localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1'b1;

    state_t              state_r, state_nxt_s;
    logic [LEN_W-1:0]    len_r, len_nxt_s;
    logic [LEN_W-1:0]    idx_r, idx_nxt_s;
    logic                phase_b_r, phase_b_nxt_s;
    logic [ADDR_W-1:0]   ptr_a_r, ptr_a_nxt_s;
    logic [ADDR_W-1:0]   ptr_b_r, ptr_b_nxt_s;
    logic [DATA_W-1:0]   mask_r, mask_nxt_s;
    logic [DATA_W-1:0]   acc_r, acc_nxt_s;
    logic [DATA_W-1:0]   hold_r, hold_nxt_s;
    logic [RD_LAT-1:0]   tag_v_r, tag_v_nxt_s;
    logic [RD_LAT-1:0]   tag_b_r, tag_b_nxt_s;
    logic [RD_LAT-1:0]   tag_l_r, tag_l_nxt_s;
    logic                rd_en_r, rd_en_nxt_s;
    logic [ADDR_W-1:0]   rd_addr_r, rd_addr_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                vt_r, vt_nxt_s;
    logic                last_s;
    logic                pend_s;
    logic                ret_v_s, ret_b_s, ret_l_s;

    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign verify_true = vt_r;

    // The in-flight read is the final pair when its word index is len-1.
    assign last_s  = (idx_r == (len_r - LEN_ONE));
    assign pend_s  = |(tag_v_r & PEND_MASK);
    assign ret_v_s = tag_v_r[RD_LAT-1];
    assign ret_b_s = tag_b_r[RD_LAT-1];
    assign ret_l_s = tag_l_r[RD_LAT-1];

    // Next-state, next-output, return-tag and accumulator logic.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        idx_nxt_s     = idx_r;
        phase_b_nxt_s = phase_b_r;
        ptr_a_nxt_s   = ptr_a_r;
        ptr_b_nxt_s   = ptr_b_r;
        mask_nxt_s    = mask_r;
        acc_nxt_s     = acc_r;
        hold_nxt_s    = hold_r;
        rd_en_nxt_s   = 1'b0;
        rd_addr_nxt_s = rd_addr_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = done_r;
        vt_nxt_s      = vt_r;

        // Tag of the read presented this cycle enters stage 0.
        tag_v_nxt_s    = tag_v_r << 1'b1;
        tag_b_nxt_s    = tag_b_r << 1'b1;
        tag_l_nxt_s    = tag_l_r << 1'b1;
        tag_v_nxt_s[0] = rd_en_r;
        tag_b_nxt_s[0] = phase_b_r;
        tag_l_nxt_s[0] = last_s;

        // Returning data: A words are parked, B words fold their masked
        // difference into the sticky accumulator (no early exit).
        if (ret_v_s && !ret_b_s) begin
            hold_nxt_s = din;
        end else if (ret_v_s && ret_b_s) begin
            acc_nxt_s = acc_r | ((hold_r ^ din) & (ret_l_s ? mask_r : ALL_ONES));
        end else begin
            hold_nxt_s = hold_r;
        end

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    len_nxt_s     = len;
                    mask_nxt_s    = last_mask;
                    acc_nxt_s     = ALL_ZERO;
                    idx_nxt_s     = LEN_ZERO;
                    phase_b_nxt_s = 1'b0;
                    rd_addr_nxt_s = base_a;
                    ptr_a_nxt_s   = base_a + ADDR_ONE;
                    ptr_b_nxt_s   = base_b;
                    busy_nxt_s    = 1'b1;
                    done_nxt_s    = 1'b0;
                    vt_nxt_s      = 1'b0;
                    if (len != LEN_ZERO) begin
                        rd_en_nxt_s = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = FINAL;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ISSUE: begin
                if (!phase_b_r) begin
                    rd_en_nxt_s   = 1'b1;
                    rd_addr_nxt_s = ptr_b_r;
                    ptr_b_nxt_s   = ptr_b_r + ADDR_ONE;
                    phase_b_nxt_s = 1'b1;
                end else if (last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    rd_en_nxt_s   = 1'b1;
                    rd_addr_nxt_s = ptr_a_r;
                    ptr_a_nxt_s   = ptr_a_r + ADDR_ONE;
                    idx_nxt_s     = idx_r + LEN_ONE;
                    phase_b_nxt_s = 1'b0;
                end
            end
            DRAIN: begin
                // Leave once only the output stage can still hold a return;
                // that return is folded in on the same edge.
                if (!pend_s) begin
                    state_nxt_s = FINAL;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            FINAL: begin
                vt_nxt_s    = (acc_r == ALL_ZERO);
                done_nxt_s  = 1'b1;
                busy_nxt_s  = 1'b0;
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, operand, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            len_r     <= LEN_ZERO;
            idx_r     <= LEN_ZERO;
            phase_b_r <= 1'b0;
            ptr_a_r   <= {ADDR_W{1'b0}};
            ptr_b_r   <= {ADDR_W{1'b0}};
            mask_r    <= ALL_ZERO;
            acc_r     <= ALL_ZERO;
            hold_r    <= ALL_ZERO;
            tag_v_r   <= {RD_LAT{1'b0}};
            tag_b_r   <= {RD_LAT{1'b0}};
            tag_l_r   <= {RD_LAT{1'b0}};
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            vt_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            idx_r     <= idx_nxt_s;
            phase_b_r <= phase_b_nxt_s;
            ptr_a_r   <= ptr_a_nxt_s;
            ptr_b_r   <= ptr_b_nxt_s;
            mask_r    <= mask_nxt_s;
            acc_r     <= acc_nxt_s;
            hold_r    <= hold_nxt_s;
            tag_v_r   <= tag_v_nxt_s;
            tag_b_r   <= tag_b_nxt_s;
            tag_l_r   <= tag_l_nxt_s;
            rd_en_r   <= rd_en_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            vt_r      <= vt_nxt_s;
        end
    end

endmodule

// File: tb/tb_verify_cmp.sv
// tb_verify_cmp: runs an RD_LAT=1 and an RD_LAT=3 comparator side by side on
// shared operands, each with its own memory read pipeline over one array.
// Expected timing, addresses and results come from a cycle-count model and a
// word-by-word block comparison.
module tb_verify_cmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  len_i;
    logic [8:0]  ba_i, bb_i;
    logic [63:0] mask_i;
    logic [1:0]  rd_en_w, busy_w, done_w, vt_w;
    logic [8:0]  rd_addr_w [2];
    logic [63:0] din_w [2];

    logic [63:0] mem [512];
    logic [63:0] q1;
    logic [63:0] q3 [3];

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    verify_cmp #(.DATA_W(64), .ADDR_W(9), .LEN_W(10), .RD_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .base_a(ba_i),
        .base_b(bb_i), .last_mask(mask_i), .rd_en(rd_en_w[0]),
        .rd_addr(rd_addr_w[0]), .din(din_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .verify_true(vt_w[0]));

    verify_cmp #(.DATA_W(64), .ADDR_W(9), .LEN_W(10), .RD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .start(start), .len(len_i), .base_a(ba_i),
        .base_b(bb_i), .last_mask(mask_i), .rd_en(rd_en_w[1]),
        .rd_addr(rd_addr_w[1]), .din(din_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .verify_true(vt_w[1]));

    // Memory with 1- and 3-cycle read latency; junk on din when not reading.
    always @(posedge clk) begin
        q1    <= rd_en_w[0] ? mem[rd_addr_w[0]] : {$urandom, $urandom};
        q3[0] <= rd_en_w[1] ? mem[rd_addr_w[1]] : {$urandom, $urandom};
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end
    assign din_w[0] = q1;
    assign din_w[1] = q3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: blocks equal if every pair matches, last pair under mask.
    function automatic logic model_eq(input int n, input logic [8:0] ba,
                                      input logic [8:0] bb, input logic [63:0] m);
        logic [63:0] d;
        logic [8:0]  a, b;
        logic        eq;
        eq = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = ba + 9'(i);
            b = bb + 9'(i);
            d = mem[a] ^ mem[b];
            if (i == n - 1) d = d & m;
            if (d != 64'd0) eq = 1'b0;
        end
        return eq;
    endfunction

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d rd_en", tag, d), 64'(rd_en_w[d]), 64'd0);
            chk($sformatf("%s d%0d rd_addr", tag, d), 64'(rd_addr_w[d]), 64'd0);
            chk($sformatf("%s d%0d busy", tag, d), 64'(busy_w[d]), 64'd0);
            chk($sformatf("%s d%0d done", tag, d), 64'(done_w[d]), 64'd0);
            chk($sformatf("%s d%0d vt", tag, d), 64'(vt_w[d]), 64'd0);
        end
    endtask

    // One operation: start sampled in cycle 0, outputs checked every cycle.
    // glitch: cycle in which a bogus start is driven; rst_at: abort cycle.
    task automatic run(input string name, input int n, input logic [8:0] ba,
                       input logic [8:0] bb, input logic [63:0] m,
                       input int glitch, input int rst_at);
        logic       exp_eq;
        int         lat, ld, i;
        logic [8:0] ea;
        exp_eq = model_eq(n, ba, bb, m);
        @(negedge clk);
        start = 1'b1; len_i = 10'(n); ba_i = ba; bb_i = bb; mask_i = m;
        for (int c = 1; c <= 2 * n + 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 3;
                ld  = (n == 0) ? 2 : 2 * n + lat + 2;
                chk($sformatf("%s d%0d c%0d busy", name, d, c), 64'(busy_w[d]), 64'(c < ld));
                chk($sformatf("%s d%0d c%0d done", name, d, c), 64'(done_w[d]), 64'(c >= ld));
                chk($sformatf("%s d%0d c%0d vt", name, d, c), 64'(vt_w[d]),
                    64'((c >= ld) && exp_eq));
                chk($sformatf("%s d%0d c%0d rd_en", name, d, c), 64'(rd_en_w[d]), 64'(c <= 2 * n));
                if (c <= 2 * n) begin
                    i  = (c - 1) / 2;
                    ea = (((c - 1) % 2) == 0) ? ba + 9'(i) : bb + 9'(i);
                    chk($sformatf("%s d%0d c%0d rd_addr", name, d, c), 64'(rd_addr_w[d]), 64'(ea));
                end
            end
            if (c == glitch) begin
                start = 1'b1; len_i = 10'd1; ba_i = ~ba; bb_i = ~bb; mask_i = 64'd0;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                chk_zero({name, " abort"});
                rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [8:0]  rb, rbb;
        logic [63:0] rm;
        int          rn, rk;
        rst = 1'b0; start = 1'b0; len_i = 10'd0; ba_i = 9'd0; bb_i = 9'd0; mask_i = 64'd0;
        for (int a = 0; a < 512; a++) mem[a] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Equal blocks, then single-bit flips in the last and first B word.
        for (int w = 0; w < 3; w++) mem[64 + w] = mem[w];
        run("eq3", 3, 9'd0, 9'd64, ONES, 0, 0);
        mem[66] = mem[66] ^ 64'h8000_0000_0000_0000;
        run("flip_w2", 3, 9'd0, 9'd64, ONES, 0, 0);
        mem[66] = mem[2];
        mem[64] = mem[64] ^ 64'h8000_0000_0000_0000;
        run("flip_w0", 3, 9'd0, 9'd64, ONES, 0, 0);
        mem[64] = mem[0];

        // Last-word mask hides the top byte only in the final pair.
        mem[66] = mem[66] ^ 64'h5A00_0000_0000_0000;
        run("mask_last", 3, 9'd0, 9'd64, 64'h00FF_FFFF_FFFF_FFFF, 0, 0);
        mem[66] = mem[2];
        mem[64] = mem[64] ^ 64'h5A00_0000_0000_0000;
        run("mask_first", 3, 9'd0, 9'd64, 64'h00FF_FFFF_FFFF_FFFF, 0, 0);
        mem[64] = mem[0];
        mem[66] = mem[66] ^ 64'h0000_0001_0000_0000;
        run("mask_zero", 3, 9'd0, 9'd64, 64'd0, 0, 0);
        mem[66] = mem[2];

        run("len0", 0, 9'd5, 9'd7, ONES, 0, 0);

        // Abort, ignored start during ISSUE, restart from DONE.
        mem[66] = mem[66] ^ 64'h8000_0000_0000_0000;
        run("abort", 3, 9'd0, 9'd64, ONES, 0, 4);
        run("glitch", 3, 9'd0, 9'd64, ONES, 3, 0);
        mem[66] = mem[2];
        run("restart", 3, 9'd0, 9'd64, ONES, 0, 0);

        // Address wrap on the B block.
        mem[510] = mem[10]; mem[511] = mem[11]; mem[0] = mem[12];
        run("wrap_eq", 3, 9'd10, 9'd510, ONES, 0, 0);
        mem[511] = mem[511] ^ 64'h0000_0000_0000_0100;
        run("wrap_ne", 3, 9'd10, 9'd510, ONES, 0, 0);

        // Randomised operations.
        for (int t = 0; t < 10; t++) begin
            rn  = $urandom_range(1, 6);
            rb  = 9'($urandom);
            rbb = 9'($urandom);
            rk  = $urandom_range(0, 3);
            rm  = ONES;
            for (int w = 0; w < rn; w++) mem[rbb + 9'(w)] = mem[rb + 9'(w)];
            if (rk == 1) begin
                rb = rb;
                mem[rbb + 9'($urandom_range(0, rn - 1))] ^= (64'd1 << $urandom_range(0, 63));
            end else if (rk == 2) begin
                mem[rbb + 9'(rn - 1)] ^= {$urandom, $urandom};
                rm = {$urandom, $urandom};
            end
            run($sformatf("rand%0d", t), rn, rb, rbb, rm, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
